// File: rtl/riscv_crypto_aes128_keygen_if.sv
// Key-in / round-key-out bundle for the AES-128 round-key generator.
// The generator sits on the slave side; the key source and round-key consumer sit on the master side.
interface riscv_crypto_aes128_keygen_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         key_dec;
    logic         abort;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         busy;

    modport master (
        output key_valid, key, key_dec, abort, rk_ready,
        input  key_ready, rk_valid, rk, rk_idx, rk_last, busy
    );

    modport slave (
        input  key_valid, key, key_dec, abort, rk_ready,
        output key_ready, rk_valid, rk, rk_idx, rk_last, busy
    );
endinterface

// File: rtl/riscv_crypto_aes128_keygen.sv
// Iterative AES-128 round-key generator streaming rk0..rk10 (encrypt) or rk10..rk0 (decrypt),
// one round key per handshake, with a forward AES S-box for SubWord.
module riscv_crypto_aes_fwd_sbox (
    input  logic [7:0] fx_in,
    output logic [7:0] fx_out
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] base;

    // Entry 0 occupies the most significant byte of the table.
    assign base   = 11'd2047 - {fx_in, 3'b000};
    assign fx_out = SBOX[base -: 8];
endmodule

module riscv_crypto_aes128_keygen #(
    parameter int DEC_EN = 1
) (
    input logic                               g_clk,
    input logic                               g_rst,
    riscv_crypto_aes128_keygen_if.slave       bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_EMIT
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  rk_q, rk_d;
    logic [3:0]    idx_q, idx_d;
    logic          rev_q, rev_d;
    logic          rk_valid_q, rk_valid_d;
    logic          rk_last_q, rk_last_d;

    logic [31:0]   w0, w1, w2, w3, w3r;
    logic [31:0]   sb_in, sb_out, t;
    logic [7:0]    rc;
    logic [3:0]    rc_idx;
    logic          sel_rev;
    logic          dec_req;
    logic [127:0]  step_fwd, step_rev, step_rk;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    assign w0 = rk_q[127:96];
    assign w1 = rk_q[95:64];
    assign w2 = rk_q[63:32];
    assign w3 = rk_q[31:0];

    // One set of four S-boxes serves both directions; the reverse step feeds the recovered w3.
    always_comb begin
        sel_rev  = (DEC_EN != 0) && rev_q && (state_q == S_EMIT);
        w3r      = w3 ^ w2;
        sb_in    = sel_rev ? {w3r[23:0], w3r[31:24]} : {w3[23:0], w3[31:24]};
        rc_idx   = sel_rev ? idx_q : idx_q + 4'd1;
        rc       = rcon(rc_idx);
        t        = sb_out ^ {rc, 24'h000000};
        step_fwd[127:96] = w0 ^ t;
        step_fwd[95:64]  = w1 ^ step_fwd[127:96];
        step_fwd[63:32]  = w2 ^ step_fwd[95:64];
        step_fwd[31:0]   = w3 ^ step_fwd[63:32];
        step_rev = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3r};
        step_rk  = sel_rev ? step_rev : step_fwd;
    end

    riscv_crypto_aes_fwd_sbox u_sbox0 (.fx_in(sb_in[31:24]), .fx_out(sb_out[31:24]));
    riscv_crypto_aes_fwd_sbox u_sbox1 (.fx_in(sb_in[23:16]), .fx_out(sb_out[23:16]));
    riscv_crypto_aes_fwd_sbox u_sbox2 (.fx_in(sb_in[15:8]),  .fx_out(sb_out[15:8]));
    riscv_crypto_aes_fwd_sbox u_sbox3 (.fx_in(sb_in[7:0]),   .fx_out(sb_out[7:0]));

    assign dec_req = (DEC_EN != 0) && bus.key_dec;

    always_comb begin
        state_d    = state_q;
        rk_d       = rk_q;
        idx_d      = idx_q;
        rev_d      = rev_q;
        rk_valid_d = rk_valid_q;
        rk_last_d  = rk_last_q;

        if (bus.abort) begin
            state_d    = S_IDLE;
            rk_valid_d = 1'b0;
            rk_last_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.key_valid) begin
                        rk_d      = bus.key;
                        idx_d     = 4'd0;
                        rev_d     = dec_req;
                        rk_last_d = 1'b0;
                        if (dec_req) begin
                            state_d    = S_EXPAND;
                            rk_valid_d = 1'b0;
                        end else begin
                            state_d    = S_EMIT;
                            rk_valid_d = 1'b1;
                        end
                    end
                end
                S_EXPAND: begin
                    rk_d  = step_rk;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd9) begin
                        state_d    = S_EMIT;
                        rk_valid_d = 1'b1;
                        rk_last_d  = 1'b0;
                    end
                end
                S_EMIT: begin
                    if (bus.rk_ready) begin
                        if (rk_last_q) begin
                            state_d    = S_IDLE;
                            rk_valid_d = 1'b0;
                            rk_last_d  = 1'b0;
                        end else begin
                            rk_d      = step_rk;
                            idx_d     = rev_q ? idx_q - 4'd1 : idx_q + 4'd1;
                            rk_last_d = rev_q ? (idx_q == 4'd1) : (idx_q == 4'd9);
                        end
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    rk_valid_d = 1'b0;
                    rk_last_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q    <= S_IDLE;
            rk_q       <= '0;
            idx_q      <= '0;
            rev_q      <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rk_q       <= rk_d;
            idx_q      <= idx_d;
            rev_q      <= rev_d;
            rk_valid_q <= rk_valid_d;
            rk_last_q  <= rk_last_d;
        end
    end

    assign bus.key_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rk_valid  = rk_valid_q;
    assign bus.rk        = rk_q;
    assign bus.rk_idx    = idx_q;
    assign bus.rk_last   = rk_last_q;
endmodule
